display_multiplexer: RTL and testbench

- Time-multiplexed driver for a bank of common-anode 7-segment displays; the stage directly downstream of the 50 MHz clock divider chain.
- Runs on the 50 MHz system clock. Uses the divider's slow display clock (~1.5 kHz) only as a sampled scan-rate input, never as a clock.
- Each scan tick either shows one digit or inserts an all-off anti-ghosting gap, cycling through every digit.

---
 rtl/display_multiplexer_if.sv | 25 ++
 rtl/display_multiplexer.sv | 196 +++++++++++++++++++
 tb/tb_display_multiplexer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/display_multiplexer_if.sv
// Signal bundle between the scan source/digit data and the display driver.
// master drives scan rate and digit data; slave drives the display pins.
interface display_multiplexer_if #(
    parameter int NUM_DIGITS = 4,
    parameter int IDX_W      = 2
);
    logic                      scan_clock;
    logic                      enable;
    logic [4*NUM_DIGITS-1:0]   digits;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic [NUM_DIGITS-1:0]     anodes;
    logic [6:0]                segments;
    logic                      dp_out;
    logic [IDX_W-1:0]          digit_index;

    modport master (
        output scan_clock, enable, digits, dp_in,
        input  anodes, segments, dp_out, digit_index
    );

    modport slave (
        input  scan_clock, enable, digits, dp_in,
        output anodes, segments, dp_out, digit_index
    );
endinterface

// File: rtl/display_multiplexer.sv
// Time-multiplexed common-anode 7-segment driver with anti-ghost gaps.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module display_multiplexer #(
    parameter int NUM_DIGITS  = 4,
    parameter int GHOST_TICKS = 1,
    parameter int IDX_W       = 2
) (
    input logic                   clock,
    input logic                   reset,
    display_multiplexer_if.slave  bus
);

    localparam int CNT_W = (GHOST_TICKS > 1) ? $clog2(GHOST_TICKS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d, idx_next;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 sync1_q, sync2_q, prev_q;
    logic                 scan_tick;
    logic                 show;
    logic [NUM_DIGITS-1:0] anodes_q, anodes_d;
    logic [6:0]           seg_q, seg_d;
    logic                 dp_q, dp_d;
    logic [3:0]           nibble;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Bring the slow scan clock into the system domain and detect rises.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= bus.scan_clock;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign scan_tick = sync2_q & ~prev_q;

    assign idx_next = (idx_q == IDX_W'(NUM_DIGITS - 1)) ?
                      '0 : idx_q + 1'b1;

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] blank_q, blank_d, lead_zero;

    // Mark each zero digit above the most significant non-zero one.
    always_comb begin
        logic run;
        lead_zero = '0;
        run       = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            run          = run & (bus.digits[i*4 +: 4] == 4'h0);
            lead_zero[i] = run;
        end
    end
`endif

    // Next-state logic: enable drop beats ticks; ticks advance the scan.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        show    = 1'b0;
        if (!bus.enable) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (scan_tick) begin
                        state_d = SHOW;
                        idx_d   = '0;
                        show    = 1'b1;
                    end
                end
                SHOW: begin
                    if (scan_tick) begin
                        if (GHOST_TICKS > 0) begin
                            state_d = GAP;
                            cnt_d   = CNT_W'(GHOST_TICKS - 1);
                        end else begin
                            state_d = SHOW;
                            idx_d   = idx_next;
                            show    = 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (scan_tick) begin
                        if (cnt_q == '0) begin
                            state_d = SHOW;
                            idx_d   = idx_next;
                            show    = 1'b1;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    assign nibble = bus.digits[{idx_d, 2'b00} +: 4];

    // Next output values; digit data is captured only on SHOW entry.
    always_comb begin
        anodes_d = anodes_q;
        seg_d    = seg_q;
        dp_d     = dp_q;
`ifdef LEADING_ZERO_BLANK_EN
        blank_d  = blank_q;
        if (show && idx_d == '0) begin
            blank_d = lead_zero;
        end
`endif
        if (state_d != SHOW) begin
            anodes_d = '1;
            seg_d    = 7'h7F;
            dp_d     = 1'b1;
        end else if (show) begin
            anodes_d = ~(NUM_DIGITS'(1) << idx_d);
`ifdef LEADING_ZERO_BLANK_EN
            seg_d    = blank_d[idx_d] ? 7'h7F : seg_decode(nibble);
`else
            seg_d    = seg_decode(nibble);
`endif
            dp_d     = ~bus.dp_in[idx_d];
        end
    end

    // State and registered display outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            anodes_q <= '1;
            seg_q    <= 7'h7F;
            dp_q     <= 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
            blank_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            anodes_q <= anodes_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
`ifdef LEADING_ZERO_BLANK_EN
            blank_q  <= blank_d;
`endif
        end
    end

    assign bus.anodes      = anodes_q;
    assign bus.segments    = seg_q;
    assign bus.dp_out      = dp_q;
    assign bus.digit_index = idx_q;

endmodule

// File: tb/tb_display_multiplexer.sv
// Directed bench for display_multiplexer with an expected-value queue.
// Covers reset, scan sequence, data latching, enable drop and reset abort.
module tb_display_multiplexer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    typedef struct {
        string      tag;
        logic [3:0] an;
        logic [6:0] sg;
        logic       dp;
        logic [1:0] ix;
    } exp_t;

    exp_t sb[$];

    display_multiplexer_if #(.NUM_DIGITS(4), .IDX_W(2)) bus ();

    display_multiplexer #(
        .NUM_DIGITS (4),
        .GHOST_TICKS(1),
        .IDX_W      (2)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] an,
                         input logic [6:0] sg, input logic dp,
                         input logic [1:0] ix);
        checks++;
        assert (bus.anodes === an) else begin
            errors++;
            $error("FAIL %s anodes got %h exp %h", tag, bus.anodes, an);
        end
        checks++;
        assert (bus.segments === sg) else begin
            errors++;
            $error("FAIL %s segments got %h exp %h", tag, bus.segments, sg);
        end
        checks++;
        assert (bus.dp_out === dp) else begin
            errors++;
            $error("FAIL %s dp_out got %b exp %b", tag, bus.dp_out, dp);
        end
        checks++;
        assert (bus.digit_index === ix) else begin
            errors++;
            $error("FAIL %s digit_index got %0d exp %0d", tag,
                   bus.digit_index, ix);
        end
        checks++;
        assert ($countones(~bus.anodes) <= 1) else begin
            errors++;
            $error("FAIL %s onehot anodes got %h exp at most one low",
                   tag, bus.anodes);
        end
    endtask

    task automatic expect_push(input string tag, input logic [3:0] an,
                               input logic [6:0] sg, input logic dp,
                               input logic [1:0] ix);
        exp_t e;
        e.tag = tag;
        e.an  = an;
        e.sg  = sg;
        e.dp  = dp;
        e.ix  = ix;
        sb.push_back(e);
    endtask

    // One full scan_clock period; compare the DUT against the queue head
    // once the rise has propagated, then let the fall pass.
    task automatic tick;
        exp_t e;
        @(negedge clk);
        bus.scan_clock = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL scoreboard got empty queue exp entry");
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, e.an, e.sg, e.dp, e.ix);
        end
        @(negedge clk);
        bus.scan_clock = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic [3:0] an,
                        input logic [6:0] sg, input logic dp,
                        input logic [1:0] ix);
        expect_push(tag, an, sg, dp, ix);
        tick();
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        bus.scan_clock = 1'b0;
        bus.enable     = 1'b0;
        bus.digits     = 16'h1234;
        bus.dp_in      = 4'b0100;

        repeat (3) @(posedge clk);
        #1;
        check("reset", 4'hF, 7'h7F, 1'b1, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("reset_hold", 4'hF, 7'h7F, 1'b1, 2'd0);

        @(negedge clk);
        bus.enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("enable_no_tick", 4'hF, 7'h7F, 1'b1, 2'd0);

        step("d0",   4'hE, 7'h19, 1'b1, 2'd0);
        step("g0",   4'hF, 7'h7F, 1'b1, 2'd0);
        step("d1",   4'hD, 7'h30, 1'b1, 2'd1);
        step("g1",   4'hF, 7'h7F, 1'b1, 2'd1);
        step("d2",   4'hB, 7'h24, 1'b0, 2'd2);
        step("g2",   4'hF, 7'h7F, 1'b1, 2'd2);
        step("d3",   4'h7, 7'h79, 1'b1, 2'd3);
        step("g3",   4'hF, 7'h7F, 1'b1, 2'd3);
        step("wrap", 4'hE, 7'h19, 1'b1, 2'd0);
        step("g0b",  4'hF, 7'h7F, 1'b1, 2'd0);
        step("d1b",  4'hD, 7'h30, 1'b1, 2'd1);
        step("g1b",  4'hF, 7'h7F, 1'b1, 2'd1);
        step("d2b",  4'hB, 7'h24, 1'b0, 2'd2);

        @(negedge clk);
        bus.digits = 16'h5678;
        repeat (5) @(posedge clk);
        #1;
        check("latched", 4'hB, 7'h24, 1'b0, 2'd2);

        step("g2c",  4'hF, 7'h7F, 1'b1, 2'd2);
        step("d3c",  4'h7, 7'h12, 1'b1, 2'd3);
        step("g3c",  4'hF, 7'h7F, 1'b1, 2'd3);
        step("d0c",  4'hE, 7'h00, 1'b1, 2'd0);
        step("g0c",  4'hF, 7'h7F, 1'b1, 2'd0);
        step("d1c",  4'hD, 7'h78, 1'b1, 2'd1);
        step("g1c",  4'hF, 7'h7F, 1'b1, 2'd1);
        step("d2c",  4'hB, 7'h02, 1'b0, 2'd2);

        @(negedge clk);
        bus.enable = 1'b0;
        @(posedge clk);
        #1;
        check("enable_drop", 4'hF, 7'h7F, 1'b1, 2'd0);
        @(negedge clk);
        bus.enable = 1'b1;
        step("reen_d0", 4'hE, 7'h00, 1'b1, 2'd0);
        step("reen_g0", 4'hF, 7'h7F, 1'b1, 2'd0);
        step("reen_d1", 4'hD, 7'h78, 1'b1, 2'd1);
        step("reen_g1", 4'hF, 7'h7F, 1'b1, 2'd1);

        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset_gap", 4'hF, 7'h7F, 1'b1, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        step("post_rst", 4'hE, 7'h00, 1'b1, 2'd0);

        @(negedge clk);
        rst          = 1'b1;
        bus.digits   = 16'h0050;
        bus.dp_in    = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        step("lz_d0", 4'hE, 7'h40, 1'b1, 2'd0);
        step("lz_g0", 4'hF, 7'h7F, 1'b1, 2'd0);
        step("lz_d1", 4'hD, 7'h12, 1'b1, 2'd1);
        step("lz_g1", 4'hF, 7'h7F, 1'b1, 2'd1);
`ifdef LEADING_ZERO_BLANK_EN
        step("lz_d2", 4'hB, 7'h7F, 1'b1, 2'd2);
        step("lz_g2", 4'hF, 7'h7F, 1'b1, 2'd2);
        step("lz_d3", 4'h7, 7'h7F, 1'b1, 2'd3);
`else
        step("lz_d2", 4'hB, 7'h40, 1'b1, 2'd2);
        step("lz_g2", 4'hF, 7'h7F, 1'b1, 2'd2);
        step("lz_d3", 4'h7, 7'h40, 1'b1, 2'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
